alu_seq_fsm: RTL and testbench
==============================

Name: alu_seq_fsm

Overview:
- Control unit that sequences one register-to-register ALU instruction (ADD/SUB/AND/OR) over the shared single-bus datapath.
- Datapath: G0–G3 general registers, P0/P1 port registers, ALU operand latch A, ALU result latch G.
- Drives the per-register bus in/out enables, the A/G latch strobes and the ALU op select, then pulses PC_inc and done.
- Sits beside the MOV sequencer; the top-level decoder starts whichever FSM owns the opcode.

Parameters:
- INSTR_W, 16, instruction word width.
- SEL_W, 3, register-select field width.
- NUM_REGS, 6, bus registers: codes 0–3 = G0–G3, 4 = P0, 5 = P1.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; instruction sampled when start=1 in IDLE.
- fullBitNum  in  INSTR_W  instruction: [15:12] opcode, [5:3] rd, [2:0] rs, [11:6] ignored.
- reg_in  out  NUM_REGS  one-hot load enables; bit i loads register code i from the bus.
- reg_out  out  NUM_REGS  one-hot bus drive enables.
- A_in  out  1  load ALU operand latch A from the bus.
- G_in  out  1  load ALU result latch G.
- G_out  out  1  G drives the bus.
- alu_op  out  2  00 ADD, 01 SUB, 10 AND, 11 OR; valid while G_in=1, else 00.
- PC_inc  out  1  one-cycle program-counter increment.
- done  out  1  one-cycle completion pulse.
- busy  out  1  high in every state except IDLE.
- illegal  out  1  high with done when the instruction was rejected.

Behaviour:
- Reset (synchronous, active-high): state IDLE, instruction latch cleared. Every output is 0 in the cycle after rst is sampled high. Reset mid-instruction aborts with no further enables.
- Outputs are decoded combinationally from the registered state and the latched instruction. At most one reg_out/G_out bit is high in any cycle.
- Opcode map: 0001 ADD, 0010 SUB, 0011 AND, 0100 OR. Any other opcode is illegal. An rd or rs code of 6 or 7 is illegal.
- State transitions:
  - IDLE: start=1 latches fullBitNum and goes to T1 if legal, otherwise to FIN with illegal flagged. start=0 stays in IDLE.
  - T1: reg_out[rd]=1, A_in=1. Go to T2.
  - T2: reg_out[rs]=1, G_in=1, alu_op per opcode. Go to T3.
  - T3: G_out=1, reg_in[rd]=1. Go to FIN.
  - FIN: PC_inc=1, done=1, illegal=latched flag. Go to IDLE.
- Latency: start at edge n gives T1 in cycle n+1 and done in cycle n+4 for a legal instruction. An illegal instruction gives done in cycle n+1 and never asserts any bus enable.
- start while busy is ignored; no queueing.
- Back-to-back: start may be asserted in the cycle after done.
- rd==rs is legal; T1 and T2 drive the same register.
- fullBitNum changes after capture have no effect.

Optional Feature:
- ALU_FLAGS_EN defined: adds output flags_in (1 bit), asserted in T2 together with G_in, so the status register captures Z/C/N from the ALU. Also adds input flags_z; when the opcode is SUB and flags_z=1 in T2, done in FIN is accompanied by an extra output zero_hit=1.
- ALU_FLAGS_EN undefined: no flags_in, flags_z or zero_hit ports; timing unchanged.

Decomposition:
- Shared package holds:
  - opcode constants (OPC_ADD/SUB/AND/OR);
  - register codes (REG_G0..REG_P1);
  - ALU op encodings;
  - state encoding (IDLE, T1, T2, T3, FIN).
- One natural sub-module: reg_sel_dec, which maps a SEL_W code to a one-hot NUM_REGS vector with an invalid flag. It is used for both rd and rs.

Test Plan:
- ADD G1,G2: rst 2 cycles, fullBitNum=16'h100A, start 1 cycle -> T1 reg_out=000001_0b (bit1) with A_in; T2 reg_out bit2 with G_in, alu_op=00; T3 G_out with reg_in bit1; done and PC_inc in cycle n+4; busy high for 4 cycles.
- SUB P0,G3: fullBitNum=16'h2023 -> T1 reg_out bit4; T2 reg_out bit3 with alu_op=01; T3 reg_in bit4; illegal=0.
- Illegal register: fullBitNum=16'h1030 (rd=6) -> done=1 and illegal=1 in cycle n+1; reg_in, reg_out, A_in, G_in and G_out stay 0 throughout.
- Illegal opcode: fullBitNum=16'h600A (MOV) -> done with illegal=1 after 1 cycle; PC_inc=1.
- Reset mid-op: start ADD, assert rst during T2 -> all outputs 0 next cycle, state IDLE. A fresh start then completes normally in 4 cycles.
- start held high during busy, then 16'h300A back-to-back after done -> second instruction begins only from IDLE, with alu_op=10 in its T2. A one-hot/mutual-exclusion assertion on reg_out and G_out holds for the whole run.

Source files
------------

// File: rtl/alu_seq_fsm_pkg.sv
// Shared constants, state encoding and opcode decode for the ALU instruction sequencer.
package alu_seq_fsm_pkg;

  localparam int INSTR_W  = 16;
  localparam int SEL_W    = 3;
  localparam int NUM_REGS = 6;

  localparam logic [3:0] OPC_ADD = 4'h1;
  localparam logic [3:0] OPC_SUB = 4'h2;
  localparam logic [3:0] OPC_AND = 4'h3;
  localparam logic [3:0] OPC_OR  = 4'h4;

  localparam logic [2:0] REG_G0 = 3'd0;
  localparam logic [2:0] REG_G1 = 3'd1;
  localparam logic [2:0] REG_G2 = 3'd2;
  localparam logic [2:0] REG_G3 = 3'd3;
  localparam logic [2:0] REG_P0 = 3'd4;
  localparam logic [2:0] REG_P1 = 3'd5;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
    ST_T3   = 3'd3,
    ST_FIN  = 3'd4
  } state_t;

  // Returns {legal, alu_op}; anything outside the four ALU opcodes is rejected.
  function automatic logic [2:0] opc_decode(input logic [3:0] opc);
    logic [2:0] res;
    case (opc)
      OPC_ADD: res = {1'b1, ALU_ADD};
      OPC_SUB: res = {1'b1, ALU_SUB};
      OPC_AND: res = {1'b1, ALU_AND};
      OPC_OR:  res = {1'b1, ALU_OR};
      default: res = {1'b0, ALU_ADD};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/alu_seq_fsm_reg_sel_dec.sv
// Register-select decoder: SEL_W code to one-hot bus enable, flagging codes with no register.
module alu_seq_fsm_reg_sel_dec #(
  parameter int SEL_W    = 3,
  parameter int NUM_REGS = 6
) (
  input  logic [SEL_W-1:0]    code,
  output logic [NUM_REGS-1:0] onehot,
  output logic                invalid
);

  // One-hot compare; an empty vector means the code names no register.
  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      onehot[i] = (code == SEL_W'(i));
    end
    invalid = ~|onehot;
  end

endmodule

// File: rtl/alu_seq_fsm.sv
// Sequencer for one register-to-register ALU instruction over the single-bus datapath.
// Optional status-flag hookup is enabled by defining ALU_FLAGS_EN.
module alu_seq_fsm
  import alu_seq_fsm_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [INSTR_W-1:0]  fullBitNum,
  output logic [NUM_REGS-1:0] reg_in,
  output logic [NUM_REGS-1:0] reg_out,
  output logic                A_in,
  output logic                G_in,
  output logic                G_out,
  output logic [1:0]          alu_op,
  output logic                PC_inc,
  output logic                done,
  output logic                busy,
`ifdef ALU_FLAGS_EN
  input  logic                flags_z,
  output logic                flags_in,
  output logic                zero_hit,
`endif
  output logic                illegal
);

  state_t              state, state_nxt;
  logic [NUM_REGS-1:0] rd_dec, rs_dec;
  logic [NUM_REGS-1:0] rd_hot, rs_hot;
  logic                rd_bad, rs_bad;
  logic                op_ok, instr_ok;
  logic [1:0]          op_dec, op_sel;
  logic                ill_flag;
  logic                unused_field;

  alu_seq_fsm_reg_sel_dec #(.SEL_W(SEL_W), .NUM_REGS(NUM_REGS)) u_rd_dec (
    .code    (fullBitNum[5:3]),
    .onehot  (rd_dec),
    .invalid (rd_bad)
  );

  alu_seq_fsm_reg_sel_dec #(.SEL_W(SEL_W), .NUM_REGS(NUM_REGS)) u_rs_dec (
    .code    (fullBitNum[2:0]),
    .onehot  (rs_dec),
    .invalid (rs_bad)
  );

  assign {op_ok, op_dec} = opc_decode(fullBitNum[15:12]);
  assign instr_ok        = op_ok & ~rd_bad & ~rs_bad;
  assign unused_field    = ^fullBitNum[11:6];

  // Instruction is kept in decoded form so later input changes cannot leak in.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      rd_hot   <= '0;
      rs_hot   <= '0;
      op_sel   <= ALU_ADD;
      ill_flag <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && start) begin
        rd_hot   <= rd_dec;
        rs_hot   <= rs_dec;
        op_sel   <= op_dec;
        ill_flag <= ~instr_ok;
      end
    end
  end

  // Next state and control strobes decoded from the current state.
  always_comb begin
    state_nxt = state;
    reg_in    = '0;
    reg_out   = '0;
    A_in      = 1'b0;
    G_in      = 1'b0;
    G_out     = 1'b0;
    alu_op    = ALU_ADD;
    PC_inc    = 1'b0;
    done      = 1'b0;
    illegal   = 1'b0;
    busy      = 1'b1;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nxt = instr_ok ? ST_T1 : ST_FIN;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_T1: begin
        reg_out   = rd_hot;
        A_in      = 1'b1;
        state_nxt = ST_T2;
      end
      ST_T2: begin
        reg_out   = rs_hot;
        G_in      = 1'b1;
        alu_op    = op_sel;
        state_nxt = ST_T3;
      end
      ST_T3: begin
        G_out     = 1'b1;
        reg_in    = rd_hot;
        state_nxt = ST_FIN;
      end
      ST_FIN: begin
        PC_inc    = 1'b1;
        done      = 1'b1;
        illegal   = ill_flag;
        state_nxt = ST_IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

`ifdef ALU_FLAGS_EN
  logic zero_flag;

  // Remembers a zero result from a SUB so FIN can report it alongside done.
  always_ff @(posedge clk) begin
    if (rst) begin
      zero_flag <= 1'b0;
    end else if (state == ST_IDLE && start) begin
      zero_flag <= 1'b0;
    end else if (state == ST_T2 && op_sel == ALU_SUB && flags_z) begin
      zero_flag <= 1'b1;
    end
  end

  assign flags_in = (state == ST_T2);
  assign zero_hit = (state == ST_FIN) & zero_flag;
`endif

endmodule

// File: tb/tb_alu_seq_fsm.sv
// Scoreboard bench for alu_seq_fsm: expected per-cycle control traces are queued at issue
// time and a negedge monitor compares each busy cycle against them.
module tb_alu_seq_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] fullBitNum = 16'h0000;
  logic [5:0]  reg_in, reg_out;
  logic        A_in, G_in, G_out, PC_inc, done, busy, illegal;
  logic [1:0]  alu_op;
`ifdef ALU_FLAGS_EN
  logic        flags_z = 1'b0;
  logic        flags_in, zero_hit;
`endif

  always #5 clk = ~clk;

  alu_seq_fsm dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .fullBitNum (fullBitNum),
    .reg_in     (reg_in),
    .reg_out    (reg_out),
    .A_in       (A_in),
    .G_in       (G_in),
    .G_out      (G_out),
    .alu_op     (alu_op),
    .PC_inc     (PC_inc),
    .done       (done),
    .busy       (busy),
`ifdef ALU_FLAGS_EN
    .flags_z    (flags_z),
    .flags_in   (flags_in),
    .zero_hit   (zero_hit),
`endif
    .illegal    (illegal)
  );

  typedef struct packed {
    logic [5:0] reg_in;
    logic [5:0] reg_out;
    logic       a_in;
    logic       g_in;
    logic       g_out;
    logic [1:0] alu_op;
    logic       pc_inc;
    logic       done;
    logic       illegal;
    logic       busy;
  } obs_t;

  obs_t exp_q[$];
  obs_t act, expv;
  int   total = 0;
  int   bad = 0;
  int   pending = 0;
  bit   chk_en = 1'b0;
  bit   rst_prev = 1'b0;

  // Reference: an instruction is a list of busy cycles derived from its fields.
  task automatic model_push(input logic [15:0] ins);
    int   opc, rd, rs;
    obs_t o;
    opc = int'(ins[15:12]);
    rd  = int'(ins[5:3]);
    rs  = int'(ins[2:0]);
    if (opc >= 1 && opc <= 4 && rd < 6 && rs < 6) begin
      o = '0; o.busy = 1'b1; o.reg_out = 6'(1 << rd); o.a_in = 1'b1;
      exp_q.push_back(o);
      o = '0; o.busy = 1'b1; o.reg_out = 6'(1 << rs); o.g_in = 1'b1; o.alu_op = 2'(opc - 1);
      exp_q.push_back(o);
      o = '0; o.busy = 1'b1; o.g_out = 1'b1; o.reg_in = 6'(1 << rd);
      exp_q.push_back(o);
      o = '0; o.busy = 1'b1; o.pc_inc = 1'b1; o.done = 1'b1;
      exp_q.push_back(o);
      pending = 4;
    end else begin
      o = '0; o.busy = 1'b1; o.pc_inc = 1'b1; o.done = 1'b1; o.illegal = 1'b1;
      exp_q.push_back(o);
      pending = 1;
    end
  endtask

  // One clock of stimulus; the model accepts start only when the unit is idle.
  task automatic cyc(input logic s, input logic [15:0] ins, input logic r);
    @(posedge clk);
    #1;
    if (rst_prev) begin
      exp_q.delete();
      pending = 0;
      chk_en  = 1'b1;
    end
    rst_prev = r;
    if (pending == 0) begin
      if (s && !r) model_push(ins);
    end else begin
      pending--;
    end
    rst        = r;
    start      = s;
    fullBitNum = ins;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 16'($urandom), 1'b0);
  endtask

  // Monitor: every cycle checks bus exclusivity, then either a queued busy cycle or quiet idle.
  always @(negedge clk) begin
    if (chk_en) begin
      act = {reg_in, reg_out, A_in, G_in, G_out, alu_op, PC_inc, done, illegal, busy};
      total++;
      if ($countones({reg_out, G_out}) > 1) begin
        bad++;
        $display("FAIL bus_excl t=%0t reg_out=%b G_out=%b required at most one driver", $time, reg_out, G_out);
      end
      total++;
      if (busy) begin
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_busy t=%0t got=%h required idle", $time, act);
        end else begin
          expv = exp_q.pop_front();
          if (act !== expv) begin
            bad++;
            $display("FAIL trace t=%0t got=%h required=%h", $time, act, expv);
          end
        end
      end else if (act !== obs_t'(0)) begin
        bad++;
        $display("FAIL idle_quiet t=%0t got=%h required=0", $time, act);
      end
    end
  end

  initial begin
    logic [3:0] opc;
    logic [2:0] rd, rs;
    logic       s, r;

    cyc(1'b0, 16'h0000, 1'b1);
    cyc(1'b0, 16'h0000, 1'b1);
    idle(2);

    cyc(1'b1, 16'h100A, 1'b0); idle(6);   // ADD G1,G2
    cyc(1'b1, 16'h2023, 1'b0); idle(6);   // SUB P0,G3
    cyc(1'b1, 16'h1030, 1'b0); idle(3);   // rd=6
    cyc(1'b1, 16'h600A, 1'b0); idle(3);   // MOV opcode
    cyc(1'b1, 16'h1012, 1'b0); idle(6);   // rd==rs

    // Reset lands while the instruction is in T2.
    cyc(1'b1, 16'h100A, 1'b0);
    cyc(1'b0, 16'h0000, 1'b0);
    cyc(1'b0, 16'h0000, 1'b1);
    cyc(1'b1, 16'h100A, 1'b0); idle(6);

    // start held through busy, then AND issued the cycle after done.
    cyc(1'b1, 16'h100A, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 16'($urandom), 1'b0);
    cyc(1'b1, 16'h300A, 1'b0); idle(6);

    for (int i = 0; i < 600; i++) begin
      opc = 4'($urandom_range(0, 6));
      rd  = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
      rs  = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
      r   = ($urandom_range(0, 49) == 0);
      s   = 1'($urandom_range(0, 1));
      cyc(s, {opc, 6'($urandom), rd, rs}, r);
    end

    for (int i = 0; i < 20 && (exp_q.size() != 0 || pending != 0 || rst_prev); i++) begin
      cyc(1'b0, 16'h0000, 1'b0);
    end
    idle(1);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d queued cycles required=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
